// File: rtl/vga_frame_crc_apb_if.sv
// APB slave bus bundle for vga_frame_crc_apb.
// The signal names match the peripheral's APB port list, so system-level
// wiring reads the same on both sides.
interface vga_frame_crc_apb_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  modport master (
    output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr
  );

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr
  );
endinterface

// File: rtl/vga_frame_crc_apb.sv
// vga_frame_crc_apb: passive monitor on a VGA pixel stream.
// It computes a reflected CRC-32 over the active pixels of each frame,
// measures the frame geometry, and counts completed frames. The results are
// read back over APB.
// Optional macro VGA_CRC_IRQ_EN adds the IRQ_MASK register at 0x18 and the irq output.
module vga_frame_crc_apb #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CNT_W = 11
) (
  input  logic                clock,
  input  logic                reset,
  vga_frame_crc_apb_if.slave  apb,
  input  logic [7:0]          vga_r,
  input  logic [7:0]          vga_g,
  input  logic [7:0]          vga_b,
  input  logic                vga_hsync,
  input  logic                vga_vsync,
  input  logic                vga_valid
`ifdef VGA_CRC_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACT);
  localparam logic [31:0]      POLY    = 32'hEDB8_8320;

  // One 24-bit step of the reflected CRC. Bytes are taken as r, g, b, and the bits of each byte LSB first.
  function automatic logic [31:0] crc24(input logic [31:0] c, input logic [23:0] d);
    logic [31:0] x;
    logic        fb;
    x = c;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) begin
        fb = x[0] ^ d[16 - 8*b + i];
        x  = (x >> 1) ^ (fb ? POLY : 32'h0);
      end
    end
    return x;
  endfunction

  // ---------------------------------------------------------------- APB decode
  logic [2:0] ofs;
  logic       acc, wr, decoded;
  logic       wr_ctrl, clr, en_off;
  logic       unused_apb;

  assign ofs     = apb.in_paddr[4:2];
  assign acc     = apb.in_psel & apb.in_penable;
  assign wr      = acc & apb.in_pwrite;
`ifdef VGA_CRC_IRQ_EN
  assign decoded = (ofs <= 3'd6);
`else
  assign decoded = (ofs <= 3'd5);
`endif
  assign wr_ctrl = wr & (ofs == 3'd0);
  assign clr     = wr_ctrl & apb.in_pwdata[1];
  assign en_off  = wr_ctrl & ~apb.in_pwdata[0];
  assign unused_apb = ^{apb.in_pprot, apb.in_pstrb, apb.in_paddr[31:5], apb.in_paddr[1:0]};

  // --------------------------------------------------------------- registers
  logic [1:0]       state_q, state_d;
  logic             en_q, en_d;
  logic             hs_q, vs_q;
  logic [31:0]      crc_q, crc_d;
  logic [CNT_W-1:0] pix_q, pix_d, line_q, line_d, lastw_q, lastw_d;
  logic             lerr_q, lerr_d;
  logic [2:0]       status_q, status_d;
  logic [31:0]      last_crc_q, last_crc_d;
  logic [31:0]      last_geom_q, last_geom_d;
  logic [31:0]      fcnt_q, fcnt_d;
  logic [31:0]      expect_q, expect_d;

  // ------------------------------------------------------- per-cycle datapath
  logic             line_end, frame_end, frame_fire;
  logic [CNT_W-1:0] pix_inc, line_inc, lastw_eff;
  logic [31:0]      crc_upd;
  logic             close_line, lerr_eff, geom_bad, mism;
  logic [2:0]       st_set, st_w1c;

  assign line_end  = hs_q & ~vga_hsync;
  assign frame_end = vs_q & ~vga_vsync;

  // A valid pixel on a line-end or frame-end cycle still belongs to the closing line/frame,
  // so every close decision below uses the values that already include this cycle's pixel.
  assign pix_inc    = (vga_valid && pix_q != CNT_MAX) ? pix_q + 1'b1 : pix_q;
  assign crc_upd    = vga_valid ? crc24(crc_q, {vga_r, vga_g, vga_b}) : crc_q;
  assign close_line = line_end && (pix_inc != '0);
  assign line_inc   = (close_line && line_q != CNT_MAX) ? line_q + 1'b1 : line_q;
  assign lastw_eff  = close_line ? pix_inc : lastw_q;
  assign lerr_eff   = lerr_q | (close_line && (pix_inc != H_ACT_C || pix_inc == CNT_MAX));
  assign geom_bad   = lerr_eff | (line_inc != V_ACT_C) | (line_inc == CNT_MAX);
  assign mism       = (expect_q != 32'h0) && (~crc_upd != expect_q);
  // When CLR lands on a frame-end cycle, CLR wins and nothing is latched.
  assign frame_fire = (state_q == ST_RUN) && frame_end && !clr;

  assign st_set = frame_fire ? {mism, geom_bad, 1'b1} : 3'b000;
  assign st_w1c = (wr && ofs == 3'd1) ? apb.in_pwdata[2:0] : 3'b000;

  // Next state for the FSM. Writing CTRL (a CLR or EN=0) overrides the normal progression.
  always_comb begin
    state_d = state_q;
    if (clr)          state_d = apb.in_pwdata[0] ? ST_SYNC : ST_IDLE;
    else if (en_off)  state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE: if (en_q)      state_d = ST_SYNC;
        ST_SYNC: if (frame_end) state_d = ST_RUN;
        ST_RUN:                 state_d = ST_RUN;
        default:                state_d = ST_IDLE;
      endcase
    end
  end

  // Accumulators. They run only in RUN and restart at every frame boundary.
  always_comb begin
    crc_d   = 32'hFFFF_FFFF;
    pix_d   = '0;
    line_d  = '0;
    lastw_d = '0;
    lerr_d  = 1'b0;
    if (state_q == ST_RUN && !clr && !en_off && !frame_end) begin
      crc_d   = crc_upd;
      pix_d   = close_line ? '0 : pix_inc;
      line_d  = line_inc;
      lastw_d = lastw_eff;
      lerr_d  = lerr_eff;
    end
  end

  // Latched results, status and software-written registers.
  always_comb begin
    en_d        = wr_ctrl ? apb.in_pwdata[0] : en_q;
    expect_d    = (wr && ofs == 3'd5) ? apb.in_pwdata : expect_q;
    last_crc_d  = last_crc_q;
    last_geom_d = last_geom_q;
    fcnt_d      = fcnt_q;
    // A status bit that is cleared and set in the same cycle stays set.
    status_d    = (status_q & ~st_w1c) | st_set;
    if (frame_fire) begin
      last_crc_d  = ~crc_upd;
      last_geom_d = (32'(line_inc) << 16) | 32'(lastw_eff);
      fcnt_d      = fcnt_q + 32'd1;
    end
    if (clr) begin
      last_crc_d  = '0;
      last_geom_d = '0;
      fcnt_d      = '0;
      status_d    = '0;
    end
  end

  // State registers, with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      crc_q       <= 32'hFFFF_FFFF;
      pix_q       <= '0;
      line_q      <= '0;
      lastw_q     <= '0;
      lerr_q      <= 1'b0;
      status_q    <= '0;
      last_crc_q  <= '0;
      last_geom_q <= '0;
      fcnt_q      <= '0;
      expect_q    <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      hs_q        <= vga_hsync;
      vs_q        <= vga_vsync;
      crc_q       <= crc_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      lastw_q     <= lastw_d;
      lerr_q      <= lerr_d;
      status_q    <= status_d;
      last_crc_q  <= last_crc_d;
      last_geom_q <= last_geom_d;
      fcnt_q      <= fcnt_d;
      expect_q    <= expect_d;
    end
  end

`ifdef VGA_CRC_IRQ_EN
  logic [2:0] irq_mask_q;
  logic       irq_q;

  // IRQ mask register. The irq output is registered from STATUS, so it trails a STATUS change by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (wr && ofs == 3'd6) irq_mask_q <= apb.in_pwdata[2:0];
      irq_q <= |(status_q & irq_mask_q);
    end
  end

  assign irq = irq_q;
`endif

  // ------------------------------------------------------------- read back
  assign apb.in_pready  = 1'b1;
  assign apb.in_pslverr = acc & ~decoded;

  // Read mux. It drives data whenever psel is high, and undecoded offsets read as 0.
  always_comb begin
    apb.in_prdata = 32'h0;
    if (apb.in_psel) begin
      case (ofs)
        3'd0: apb.in_prdata = {31'h0, en_q};
        3'd1: apb.in_prdata = {29'h0, status_q};
        3'd2: apb.in_prdata = last_crc_q;
        3'd3: apb.in_prdata = last_geom_q;
        3'd4: apb.in_prdata = fcnt_q;
        3'd5: apb.in_prdata = expect_q;
`ifdef VGA_CRC_IRQ_EN
        3'd6: apb.in_prdata = {29'h0, irq_mask_q};
`endif
        default: apb.in_prdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_crc_apb.sv
// Self-checking bench for vga_frame_crc_apb. It runs with H_ACT=4 and V_ACT=2,
// so the synthetic frames stay short.
module tb_vga_frame_crc_apb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_frame_crc_apb_if apb();
  logic [7:0] r, g, b;
  logic       hs, vs, vld;
`ifdef VGA_CRC_IRQ_EN
  logic       irq;
`endif

  vga_frame_crc_apb #(.H_ACT(4), .V_ACT(2), .CNT_W(11)) dut (
    .clock(clk), .reset(rst), .apb(apb),
    .vga_r(r), .vga_g(g), .vga_b(b),
    .vga_hsync(hs), .vga_vsync(vs), .vga_valid(vld)
`ifdef VGA_CRC_IRQ_EN
    , .irq(irq)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [31:0] mask;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;
  vec_t tbl[8];

  logic [31:0] crc_good, crc_tmp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] crc_model(input logic [7:0] bq[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (bq[k]) begin
      for (int i = 0; i < 8; i++) begin
        if (c[0] ^ bq[k][i]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                 c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
    apb.in_psel = 1'b1; apb.in_penable = 1'b0; apb.in_pwrite = 1'b1;
    apb.in_paddr = addr; apb.in_pwdata = data;
    tick();
    apb.in_penable = 1'b1;
    tick();
    apb.in_psel = 1'b0; apb.in_penable = 1'b0; apb.in_pwrite = 1'b0;
  endtask

  // Reads one register. The expectation goes onto the scoreboard first, then the access phase is sampled and checked against it.
  task automatic apb_rd(input logic [31:0] addr, input string nm, input logic [31:0] exp,
                        input logic [31:0] mask, input logic exp_err);
    exp_t e;
    logic [31:0] rd;
    logic er, rdy;
    sb.push_back('{nm, exp, mask, exp_err});
    apb.in_psel = 1'b1; apb.in_penable = 1'b0; apb.in_pwrite = 1'b0; apb.in_paddr = addr;
    tick();
    apb.in_penable = 1'b1;
    #1;
    rd = apb.in_prdata; er = apb.in_pslverr; rdy = apb.in_pready;
    tick();
    apb.in_psel = 1'b0; apb.in_penable = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (((rd & e.mask) !== (e.data & e.mask)) || (er !== e.err) || (rdy !== 1'b1)) begin
      n_err++;
      $display("FAIL %s: got data=%h slverr=%b pready=%b, expected data=%h (mask %h) slverr=%b pready=1",
               e.name, rd, er, rdy, e.data, e.mask, e.err);
    end
  endtask

  // Drives the active lines of one frame (pixel value = index, placed in the blue byte) but not the vsync fall.
  task automatic frame_body(input int n0, input int n1, output logic [31:0] crc);
    int lens[2];
    int idx;
    logic [7:0] bq[$];
    lens = '{n0, n1};
    idx = 0;
    bq = {};
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < lens[l]; p++) begin
        vld = 1'b1; r = 8'h00; g = 8'h00; b = 8'(idx);
        bq.push_back(8'h00); bq.push_back(8'h00); bq.push_back(8'(idx));
        idx++;
        tick();
      end
      vld = 1'b0;
      hs = 1'b0; tick();
      hs = 1'b1; tick();
    end
    crc = crc_model(bq);
  endtask

  task automatic vs_fall();
    vs = 1'b0; tick();
    vs = 1'b1; tick();
  endtask

  task automatic frame(input int n0, input int n1, output logic [31:0] crc);
    frame_body(n0, n1, crc);
    vs_fall();
  endtask

  initial begin
    apb.in_paddr = '0; apb.in_psel = 1'b0; apb.in_penable = 1'b0; apb.in_pprot = '0;
    apb.in_pwrite = 1'b0; apb.in_pwdata = '0; apb.in_pstrb = 4'hF;
    r = '0; g = '0; b = '0; hs = 1'b1; vs = 1'b1; vld = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state of every offset.
    for (int i = 0; i < 8; i++) tbl[i] = '{32'(i * 4), 32'h0, 1'b0};
`ifndef VGA_CRC_IRQ_EN
    tbl[6].err = 1'b1;
`endif
    tbl[7].err = 1'b1;
    for (int i = 0; i < 8; i++)
      apb_rd(tbl[i].addr, $sformatf("reset_rd_%02h", tbl[i].addr), tbl[i].data, 32'hFFFF_FFFF, tbl[i].err);

    // Two good frames. The first is spent in SYNC, so only the second is counted.
    apb_wr(32'h00, 32'h1);
    tick(); tick();
    frame(4, 4, crc_tmp);
    frame(4, 4, crc_good);
    apb_rd(32'h10, "fcnt_after_2", 32'd1, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h0C, "geom_good", 32'h0002_0004, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h04, "status_good", 32'h1, 32'h7, 1'b0);
    apb_rd(32'h08, "crc_good", crc_good, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h00, "ctrl_rd", 32'h1, 32'hFFFF_FFFF, 1'b0);

    // A short line sets GEOM_ERR, and a W1C clears it.
    frame(3, 4, crc_tmp);
    apb_rd(32'h04, "geom_err_set", 32'h2, 32'h2, 1'b0);
    apb_rd(32'h0C, "geom_short", 32'h0002_0004, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h08, "crc_short", crc_tmp, 32'hFFFF_FFFF, 1'b0);
    apb_wr(32'h04, 32'h2);
    apb_rd(32'h04, "geom_err_w1c", 32'h0, 32'h2, 1'b0);

    // A wrong EXPECT_CRC sets MISMATCH. After the correct value and a W1C, it stays clear.
    apb_wr(32'h14, 32'h1234_5678);
    frame(4, 4, crc_tmp);
    apb_rd(32'h04, "mismatch_set", 32'h4, 32'h4, 1'b0);
    apb_wr(32'h14, crc_good);
    apb_rd(32'h14, "expect_rd", crc_good, 32'hFFFF_FFFF, 1'b0);
    apb_wr(32'h04, 32'h4);
    frame(4, 4, crc_tmp);
    apb_rd(32'h04, "mismatch_clear", 32'h0, 32'h4, 1'b0);
    apb_rd(32'h10, "fcnt_4", 32'd4, 32'hFFFF_FFFF, 1'b0);

    // EN is dropped mid-frame and then raised again. The next frame only resynchronises.
    vld = 1'b1; b = 8'h00; tick();
    b = 8'h01; tick();
    vld = 1'b0;
    apb_wr(32'h00, 32'h0);
    apb_wr(32'h00, 32'h1);
    tick(); tick();
    frame(4, 4, crc_tmp);
    apb_rd(32'h10, "fcnt_resync", 32'd4, 32'hFFFF_FFFF, 1'b0);
    frame(4, 4, crc_tmp);
    apb_rd(32'h10, "fcnt_after_resync", 32'd5, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h08, "crc_after_resync", crc_good, 32'hFFFF_FFFF, 1'b0);

    // CLR lands in the exact frame-end cycle. The clear wins.
    frame_body(4, 4, crc_tmp);
    apb.in_psel = 1'b1; apb.in_penable = 1'b0; apb.in_pwrite = 1'b1;
    apb.in_paddr = 32'h00; apb.in_pwdata = 32'h3;
    tick();
    apb.in_penable = 1'b1; vs = 1'b0;
    tick();
    apb.in_psel = 1'b0; apb.in_penable = 1'b0; apb.in_pwrite = 1'b0; vs = 1'b1;
    tick();
    apb_rd(32'h10, "fcnt_clr", 32'd0, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h04, "status_clr", 32'h0, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h08, "crc_clr", 32'h0, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h0C, "geom_clr", 32'h0, 32'hFFFF_FFFF, 1'b0);

`ifdef VGA_CRC_IRQ_EN
    apb_wr(32'h18, 32'h1);
    apb_rd(32'h18, "irq_mask_rd", 32'h1, 32'hFFFF_FFFF, 1'b0);
`endif
    // After CLR the block is in SYNC again. One frame resynchronises, and the next one completes.
    frame(4, 4, crc_tmp);
    apb_rd(32'h04, "status_sync", 32'h0, 32'h1, 1'b0);
    frame_body(4, 4, crc_tmp);
    vs = 1'b0; tick();
`ifdef VGA_CRC_IRQ_EN
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
`endif
    vs = 1'b1; tick();
`ifdef VGA_CRC_IRQ_EN
    chk("irq_rise", {31'h0, irq}, 32'h1);
`endif
    apb_rd(32'h04, "done_after_clr", 32'h1, 32'h1, 1'b0);
    apb_rd(32'h10, "fcnt_after_clr", 32'd1, 32'hFFFF_FFFF, 1'b0);
    apb_rd(32'h08, "crc_after_clr", crc_good, 32'hFFFF_FFFF, 1'b0);
    apb_wr(32'h04, 32'h1);
`ifdef VGA_CRC_IRQ_EN
    chk("irq_hold", {31'h0, irq}, 32'h1);
    tick();
    chk("irq_fall", {31'h0, irq}, 32'h0);
`endif
    apb_rd(32'h04, "done_w1c", 32'h0, 32'h1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: if the run overruns, it still reports and stops on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected completion before 200000 time units");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vga_frame_crc_apb.md
Name: vga_frame_crc_apb

Overview:
- Passive monitor sitting directly downstream of the APB VGA framebuffer peripheral.
- Taps its vga_r/g/b, vga_hsync, vga_vsync and vga_valid outputs and computes a per-frame CRC-32 over active pixels.
- Measures frame geometry (pixels per active line, active lines per frame) and counts completed frames.
- Results are read back over its own APB slave port, so software and testbenches can check displayed content without a screen model.

Parameters:
- H_ACT, 640, expected valid pixels per active line.
- V_ACT, 480, expected active lines per frame.
- CNT_W, 11, width of the pixel and line counters; saturating.

Ports:
- clock  in  1  system clock; also the pixel clock.
- reset  in  1  synchronous, active-high reset.
- in_paddr  in  32  APB address; only [4:2] decoded.
- in_psel  in  1  APB select.
- in_penable  in  1  APB enable.
- in_pprot  in  3  ignored.
- in_pwrite  in  1  APB write.
- in_pwdata  in  32  APB write data.
- in_pstrb  in  4  ignored; all writes are full-word.
- in_pready  out  1  constant 1 (zero wait states).
- in_prdata  out  32  read data.
- in_pslverr  out  1  error for an undecoded offset.
- vga_r/vga_g/vga_b  in  8 each  pixel colour.
- vga_hsync  in  1  active-low horizontal sync.
- vga_vsync  in  1  active-low vertical sync.
- vga_valid  in  1  active-pixel qualifier.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- APB access: write when psel&penable&pwrite; read data is driven combinationally whenever psel is high.
  - Offsets 0x00-0x14 are decoded; 0x18-0x1C return pslverr=1 during psel&penable, with no side effects and prdata=0.
- Registers, with reset values:
  - 0x00 CTRL, RW: bit0 EN=0; bit1 CLR is write-1, self-clearing, reads 0.
  - 0x04 STATUS: bit0 DONE (sticky, W1C); bit1 GEOM_ERR (sticky, W1C); bit2 MISMATCH (sticky, W1C); all 0.
  - 0x08 LAST_CRC, RO = 0.
  - 0x0C LAST_GEOM, RO: [26:16] active line count, [10:0] width of last active line; 0.
  - 0x10 FRAME_CNT, RO = 0; 32-bit, wraps.
  - 0x14 EXPECT_CRC, RW = 0.
- Edge detect: hsync and vsync are registered. A line end is a falling edge of hsync (1->0); a frame end is a falling edge of vsync.
- State machine:
  - IDLE: entered on reset or when EN=0; accumulators are held cleared.
  - IDLE -> SYNC when EN=1.
  - SYNC: the partial frame is discarded; SYNC -> RUN on the first frame end. No results are latched on this edge.
  - RUN: every cycle with vga_valid=1, the CRC absorbs 24 bits {r,g,b} and pix_cnt increments.
  - RUN, at line end with pix_cnt!=0: line_cnt++, last_w<=pix_cnt, pix_cnt<=0. If pix_cnt!=H_ACT, set the line_err flag.
  - RUN, at frame end: in that same cycle, latch LAST_CRC=~crc and LAST_GEOM; FRAME_CNT++; DONE=1.
    - GEOM_ERR |= line_err | (line_cnt!=V_ACT).
    - MISMATCH |= (~crc != EXPECT_CRC) if EXPECT_CRC != 0.
    - Reinit crc=0xFFFFFFFF; clear counters and line_err.
  - Any state -> IDLE when EN is written 0; accumulators are discarded, latched registers keep their values.
- CRC definition:
  - Reflected CRC-32 (poly 0xEDB88320), init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Bytes processed in order r, g, b, each LSB-first.
  - Single-cycle 24-bit combinational update.
- Simultaneous events:
  - A W1C of a STATUS bit in the same cycle it is set: the set wins.
  - CLR in the same cycle as a frame end: the clear wins. CLR zeroes STATUS, LAST_*, FRAME_CNT and accumulators, then returns to SYNC if EN=1.
  - vga_valid high during a line-end cycle: the pixel counts toward the closing line.
- Counters saturate at 2^CNT_W-1; a saturated count sets GEOM_ERR at frame end.

Optional Feature:
- Macro: VGA_CRC_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) = |(STATUS & IRQ_MASK).
  - Adds RW register 0x18 IRQ_MASK[2:0], reset 0; 0x18 then no longer raises pslverr.
  - irq is registered: it asserts the cycle after the STATUS bit sets and deasserts the cycle after W1C.
- Undefined: no irq port, 0x18 is undecoded, and there is no IRQ_MASK storage.

Test Plan:
- Reset, then read all offsets: -> every register reads 0, pready=1. A read of 0x1C gives pslverr=1 (without VGA_CRC_IRQ_EN, 0x18 also gives pslverr=1).
- H_ACT=4, V_ACT=2, EN=1; drive 2 synthetic frames of 2 lines x 4 pixels with pixel value = index:
  - -> after frame 2, FRAME_CNT=1 (frame 1 consumed in SYNC).
  - -> LAST_GEOM=0x0002_0004, GEOM_ERR=0.
  - -> LAST_CRC equals the CRC-32 software model of bytes 00 00 00, 00 00 01 … 00 00 07.
- Same setup with one line carrying 3 pixels -> GEOM_ERR=1, LAST_GEOM[10:0]=4 (last line full); W1C 0x2 to 0x04 -> GEOM_ERR=0.
- Write EXPECT_CRC=0x12345678 (wrong), run one frame -> MISMATCH=1. Write the correct model value, W1C, run one more frame -> MISMATCH stays 0.
- Write EN=0 mid-frame, then EN=1 -> FRAME_CNT unchanged until one full frame after the next vsync fall.
- Write CTRL=0x3 in the exact frame-end cycle -> FRAME_CNT=0, DONE=0. With VGA_CRC_IRQ_EN and IRQ_MASK=1, irq rises 1 cycle after the next DONE.
